// File: rtl/if_id_queue.sv
// -----------------------------------------------------------------------------
// if_id_queue
//   DEPTH-entry FIFO of fetch bundles between instruction fetch and decode.
//   Each bundle is one PC, FETCH_W 32-bit instruction words and a per-slot
//   valid mask. The queue uses a valid/ready handshake on both sides and can
//   be flushed on a branch mispredict or an exception redirect.
//
//   Optional feature macro: IF_ID_Q_OCC_EN
//     Defined   -> the occupancy port is present and shows the registered
//                  entry count.
//     Undefined -> the port and its logic are absent. Core behaviour is
//                  the same.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active-high
//   flush      in   synchronous discard of all entries
//   in_valid   in   fetch presents a bundle
//   in_ready   out  queue can accept a bundle
//   in_pc      in   bundle PC
//   in_inst    in   slot i = bits [32*i+31:32*i]
//   in_mask    in   per-slot valid
//   out_valid  out  head bundle available to decode
//   out_ready  in   decode consumes the head
//   out_pc     out  head PC (0 when empty)
//   out_inst   out  head instructions (0 when empty)
//   out_mask   out  head slot-valid mask (0 when empty)
//   occupancy  out  entry count [IF_ID_Q_OCC_EN only]
// -----------------------------------------------------------------------------
module if_id_queue #(
  parameter int FETCH_W = 4,
  parameter int DEPTH   = 4,
  parameter int PC_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PC_W-1:0]       in_pc,
  input  logic [32*FETCH_W-1:0] in_inst,
  input  logic [FETCH_W-1:0]    in_mask,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PC_W-1:0]       out_pc,
  output logic [32*FETCH_W-1:0] out_inst,
  output logic [FETCH_W-1:0]    out_mask
`ifdef IF_ID_Q_OCC_EN
  ,
  output logic [$clog2(DEPTH):0] occupancy
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Bundle storage. It is not reset: entries are only visible through the
  // count, so stale contents can never reach the outputs.
  logic [PC_W-1:0]       r_pc_mem   [DEPTH];
  logic [32*FETCH_W-1:0] r_inst_mem [DEPTH];
  logic [FETCH_W-1:0]    r_mask_mem [DEPTH];

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_push;
  logic w_pop;
  logic w_in_ready;
  logic w_out_valid;

  // in_ready comes only from the registered count. There is no pass-through
  // when full, so fetch never sees a combinational path from out_ready.
  assign w_in_ready  = (r_count != CW'(DEPTH));
  assign w_out_valid = (r_count != {CW{1'b0}});

  // A bundle with an all-zero mask completes the handshake but holds no
  // work, so it is dropped instead of taking up an entry.
  assign w_push = in_valid & w_in_ready & (|in_mask);
  assign w_pop  = w_out_valid & out_ready;

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;

`ifdef IF_ID_Q_OCC_EN
  assign occupancy = r_count;
`endif

  // Pointer and count state. Flush wins over push/pop. Pointers wrap
  // modulo DEPTH because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else if (flush) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Write the accepted bundle into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_pc_mem[r_wr_ptr]   <= in_pc;
      r_inst_mem[r_wr_ptr] <= in_inst;
      r_mask_mem[r_wr_ptr] <= in_mask;
    end
  end

  // Head read. Outputs are forced to zero when empty, which gives the same
  // bubble as the single-entry IF/ID register.
  always_comb begin
    out_pc   = {PC_W{1'b0}};
    out_inst = {(32*FETCH_W){1'b0}};
    out_mask = {FETCH_W{1'b0}};
    if (w_out_valid) begin
      out_pc   = r_pc_mem[r_rd_ptr];
      out_inst = r_inst_mem[r_rd_ptr];
      out_mask = r_mask_mem[r_rd_ptr];
    end else begin
      out_pc   = {PC_W{1'b0}};
      out_inst = {(32*FETCH_W){1'b0}};
      out_mask = {FETCH_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;
  localparam int FW = 4;
  localparam int DP = 4;
  localparam int PW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [PW-1:0]     in_pc;
  logic [32*FW-1:0]  in_inst;
  logic [FW-1:0]     in_mask;
  logic              out_valid;
  logic              out_ready;
  logic [PW-1:0]     out_pc;
  logic [32*FW-1:0]  out_inst;
  logic [FW-1:0]     out_mask;
`ifdef IF_ID_Q_OCC_EN
  logic [2:0]        occupancy;
`endif

  if_id_queue #(.FETCH_W(FW), .DEPTH(DP), .PC_W(PW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_inst(in_inst), .in_mask(in_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst(out_inst), .out_mask(out_mask)
`ifdef IF_ID_Q_OCC_EN
    , .occupancy(occupancy)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [PW-1:0]    pc;
    logic [32*FW-1:0] inst;
    logic [FW-1:0]    mask;
  } bundle_t;

  bundle_t model_q[$];

  typedef struct {
    logic          fl;
    logic          iv;
    logic [31:0]   pc;
    logic [3:0]    mask;
    logic          ordy;
    logic          ev;
    logic          er;
    logic [31:0]   epc;
    logic [3:0]    emask;
  } vec_t;

  vec_t tbl[18];

  function automatic logic [32*FW-1:0] inst_of(input logic [31:0] pc);
    return {pc ^ 32'hA5A5_0003, pc ^ 32'h5A5A_0002, pc ^ 32'h0F0F_0001, pc};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the queue model.
  task automatic check_model();
    bundle_t h;
    h = '0;
    if (model_q.size() != 0) h = model_q[0];
    chk("m_out_valid", {127'd0, out_valid}, {127'd0, model_q.size() != 0});
    chk("m_in_ready", {127'd0, in_ready}, {127'd0, model_q.size() != DP});
    chk("m_out_pc", {96'd0, out_pc}, {96'd0, h.pc});
    chk("m_out_inst", out_inst, h.inst);
    chk("m_out_mask", {124'd0, out_mask}, {124'd0, h.mask});
`ifdef IF_ID_Q_OCC_EN
    chk("m_occupancy", {125'd0, occupancy}, 128'(model_q.size()));
`endif
  endtask

  // One clock with the currently driven inputs; update the model at the edge.
  task automatic step();
    bit push;
    bit pop;
    bundle_t b;
    push = in_valid && (model_q.size() != DP) && (in_mask != 4'd0);
    pop  = out_ready && (model_q.size() != 0);
    b.pc = in_pc; b.inst = in_inst; b.mask = in_mask;
    @(posedge clk);
    #1;
    if (flush) model_q.delete();
    else begin
      if (pop) void'(model_q.pop_front());
      if (push) model_q.push_back(b);
    end
    check_model();
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [31:0] pc,
                       input logic [3:0] mask, input logic ordy);
    flush = fl; in_valid = iv; in_pc = pc; in_inst = inst_of(pc);
    in_mask = mask; out_ready = ordy;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 4'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("rst_out_pc", {96'd0, out_pc}, 128'd0);
    chk("rst_out_mask", {124'd0, out_mask}, 128'd0);
    rst = 1'b0;

    //            fl    iv    pc         mask   ordy  ev    er    epc        emask
    tbl[0]  = '{1'b0, 1'b1, 32'h100, 4'hF, 1'b0, 1'b1, 1'b1, 32'h100, 4'hF};
    tbl[1]  = '{1'b0, 1'b1, 32'h110, 4'hF, 1'b0, 1'b1, 1'b1, 32'h100, 4'hF};
    tbl[2]  = '{1'b0, 1'b1, 32'h120, 4'hF, 1'b0, 1'b1, 1'b1, 32'h100, 4'hF};
    tbl[3]  = '{1'b0, 1'b1, 32'h130, 4'hF, 1'b0, 1'b1, 1'b0, 32'h100, 4'hF};
    tbl[4]  = '{1'b0, 1'b1, 32'h140, 4'hF, 1'b0, 1'b1, 1'b0, 32'h100, 4'hF};
    tbl[5]  = '{1'b0, 1'b1, 32'h140, 4'hF, 1'b1, 1'b1, 1'b1, 32'h110, 4'hF};
    tbl[6]  = '{1'b0, 1'b1, 32'h140, 4'hF, 1'b1, 1'b1, 1'b1, 32'h120, 4'hF};
    tbl[7]  = '{1'b0, 1'b0, 32'h000, 4'h0, 1'b1, 1'b1, 1'b1, 32'h130, 4'hF};
    tbl[8]  = '{1'b0, 1'b0, 32'h000, 4'h0, 1'b1, 1'b1, 1'b1, 32'h140, 4'hF};
    tbl[9]  = '{1'b0, 1'b0, 32'h000, 4'h0, 1'b1, 1'b0, 1'b1, 32'h000, 4'h0};
    tbl[10] = '{1'b0, 1'b1, 32'h300, 4'h0, 1'b0, 1'b0, 1'b1, 32'h000, 4'h0};
    tbl[11] = '{1'b0, 1'b1, 32'h310, 4'h5, 1'b0, 1'b1, 1'b1, 32'h310, 4'h5};
    tbl[12] = '{1'b0, 1'b0, 32'h000, 4'h0, 1'b1, 1'b0, 1'b1, 32'h000, 4'h0};
    tbl[13] = '{1'b0, 1'b1, 32'h180, 4'h3, 1'b0, 1'b1, 1'b1, 32'h180, 4'h3};
    tbl[14] = '{1'b0, 1'b1, 32'h190, 4'hF, 1'b0, 1'b1, 1'b1, 32'h180, 4'h3};
    tbl[15] = '{1'b0, 1'b1, 32'h1A0, 4'hF, 1'b0, 1'b1, 1'b1, 32'h180, 4'h3};
    tbl[16] = '{1'b1, 1'b1, 32'h200, 4'hF, 1'b1, 1'b0, 1'b1, 32'h000, 4'h0};
    tbl[17] = '{1'b0, 1'b0, 32'h000, 4'h0, 1'b0, 1'b0, 1'b1, 32'h000, 4'h0};

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].fl, tbl[i].iv, tbl[i].pc, tbl[i].mask, tbl[i].ordy);
      step();
      chk($sformatf("vec%0d_out_valid", i), {127'd0, out_valid}, {127'd0, tbl[i].ev});
      chk($sformatf("vec%0d_in_ready", i), {127'd0, in_ready}, {127'd0, tbl[i].er});
      chk($sformatf("vec%0d_out_pc", i), {96'd0, out_pc}, {96'd0, tbl[i].epc});
      chk($sformatf("vec%0d_out_mask", i), {124'd0, out_mask}, {124'd0, tbl[i].emask});
    end

    // Steady push+pop at two entries; pointers wrap twice over 8 cycles.
    drive(1'b0, 1'b1, 32'h400, 4'hF, 1'b0); step();
    drive(1'b0, 1'b1, 32'h410, 4'hF, 1'b0); step();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 32'h420 + 32'(i) * 32'h10, 4'(i + 1), 1'b1);
      step();
      chk("pp_out_valid", {127'd0, out_valid}, 128'd1);
      chk("pp_in_ready", {127'd0, in_ready}, 128'd1);
      chk("pp_head_pc", {96'd0, out_pc}, {96'd0, 32'h410 + 32'(i) * 32'h10});
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 19) == 0), $urandom_range(0, 1) == 1, $urandom,
            ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom), $urandom_range(0, 2) != 0);
      step();
    end

    // Make sure the queue holds something, then reset asynchronously.
    drive(1'b0, 1'b1, 32'h500, 4'h9, 1'b0); step();
    drive(1'b0, 1'b1, 32'h510, 4'h9, 1'b0); step();
    rst = 1'b1;
    #1;
    model_q.delete();
    chk("arst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("arst_out_pc", {96'd0, out_pc}, 128'd0);
    chk("arst_in_ready", {127'd0, in_ready}, 128'd1);
`ifdef IF_ID_Q_OCC_EN
    chk("arst_occupancy", {125'd0, occupancy}, 128'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 4'h0, 1'b1);
    step();
    chk("post_rst_empty", {127'd0, out_valid}, 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
